mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and data access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_MAX_BURST = 4,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]          c_MAX_BURST = 3'(DATA_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_streak;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_discard;
  logic                w_busy;
  logic                w_ack;
  logic                w_timeout;
  logic                w_burst_full;
  logic                w_grant_f;
  logic                w_grant_d;

  assign w_busy       = (r_state == FETCH) || (r_state == DATA);
  assign w_ack        = w_busy & mem_ack;
  // The last wait cycle times out unless the ack shows up in it.
  assign w_timeout    = w_busy & ~mem_ack & (r_wait == c_WAIT_LAST);
  assign w_burst_full = (r_streak == c_MAX_BURST);

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  always_comb begin
    w_grant_f    = 1'b0;
    w_grant_d    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        w_grant_f = if_req & ~flush & (~d_req | w_burst_full);
        w_grant_d = d_req & ~w_grant_f;
        if (w_grant_f) begin
          w_next_state = FETCH;
        end else if (w_grant_d) begin
          w_next_state = DATA;
        end
      end
      FETCH, DATA: begin
        if (w_ack || w_timeout) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_streak  <= 3'd0;
      r_wait    <= '0;
      r_discard <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      if_rdata  <= 32'h0;
      if_valid  <= 1'b0;
      d_rdata   <= 32'h0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (w_grant_f || w_grant_d) begin
        mem_req   <= 1'b1;
        r_wait    <= '0;
        mem_we    <= w_grant_d & d_we;
        mem_be    <= w_grant_d ? d_be : 4'hF;
        mem_addr  <= w_grant_d ? d_addr : if_addr;
        mem_wdata <= w_grant_d ? d_wdata : 32'h0;
      end

      if (w_grant_f) begin
        r_streak <= 3'd0;
      end else if (w_grant_d) begin
        r_streak <= !if_req ? 3'd0 : (w_burst_full ? r_streak : r_streak + 3'd1);
      end

      if (r_state == FETCH && flush) begin
        r_discard <= 1'b1;
      end else if (r_state == RESP) begin
        r_discard <= 1'b0;
      end

      // A flush arriving together with the ack still discards the fetch.
      if (w_ack || w_timeout) begin
        mem_req <= 1'b0;
        if (r_state == FETCH) begin
          if (!(r_discard || flush)) begin
            if_valid <= 1'b1;
            if_rdata <= w_ack ? mem_rdata : 32'h0;
          end
        end else begin
          d_valid <= 1'b1;
          if (!mem_we) begin
            d_rdata <= w_ack ? mem_rdata : 32'h0;
          end
        end
      end else if (w_busy) begin
        r_wait <= r_wait + 1'b1;
      end

      if (w_timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Transaction-level reference model plus directed and random runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int DATA_MAX_BURST = 4;
  localparam int TIMEOUT_CYC    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_mem, bus_err;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.DATA_MAX_BURST(DATA_MAX_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK(clk), .RST(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction record plus a response flag.
  bit          m_busy, m_fetch, m_resp, m_discard;
  bit          m_mem_req, m_we, m_if_valid, m_d_valid, m_bus_err;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_age, m_streak;

  byte  glog[$];
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_resp = 0; m_discard = 0; m_mem_req = 0; m_we = 0;
    m_if_valid = 0; m_d_valid = 0; m_bus_err = 0; m_be = 4'h0; m_addr = 32'h0;
    m_wdata = 32'h0; m_if_rdata = 32'h0; m_d_rdata = 32'h0; m_age = 0; m_streak = 0;
  endtask

  task automatic start_txn(input bit fetch, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    m_busy = 1; m_mem_req = 1; m_fetch = fetch; m_we = we; m_be = be;
    m_addr = addr; m_wdata = wdata; m_age = 0;
  endtask

  task automatic finish_txn(input logic [31:0] data);
    m_busy = 0; m_mem_req = 0; m_resp = 1;
    if (m_fetch) begin
      if (!m_discard) begin
        m_if_rdata = data;
        m_if_valid = 1;
      end
    end else begin
      if (!m_we) m_d_rdata = data;
      m_d_valid = 1;
    end
  endtask

  task automatic model_step();
    bit gf;
    if (rst) begin
      model_reset();
      return;
    end
    m_if_valid = 0;
    m_d_valid  = 0;
    if (m_resp) begin
      m_resp = 0;
      m_discard = 0;
    end else if (m_busy) begin
      if (m_fetch && flush) m_discard = 1;
      if (mem_ack) finish_txn(mem_rdata);
      else if (m_age == TIMEOUT_CYC - 1) begin
        m_bus_err = 1;
        finish_txn(32'h0);
      end else m_age++;
    end else begin
      gf = if_req && !flush && (!d_req || m_streak == DATA_MAX_BURST);
      if (gf) begin
        start_txn(1, 0, 4'hF, if_addr, 32'h0);
        m_streak = 0;
      end else if (d_req) begin
        start_txn(0, d_we, d_be, d_addr, d_wdata);
        m_streak = if_req ? ((m_streak < DATA_MAX_BURST) ? m_streak + 1 : m_streak) : 0;
      end
    end
  endtask

  task automatic compare_all();
    check("mem_req", mem_req, m_mem_req);
    if (m_mem_req) begin
      check("mem_we", mem_we, m_we);
      check("mem_be", mem_be, m_be);
      check("mem_addr", mem_addr, m_addr);
      if (!m_fetch) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("if_valid", if_valid, m_if_valid);
    check("d_valid", d_valid, m_d_valid);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    check("bus_err", bus_err, m_bus_err);
    check("stall_if", stall_if, if_req & ~m_if_valid);
    check("stall_mem", stall_mem, d_req & ~m_d_valid);
    if (mem_req && !prev_req) glog.push_back(mem_we ? "D" : "F");
    prev_req = mem_req;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic rand_drive();
    flush = ($urandom_range(0, 7) == 0);
    rst   = ($urandom_range(0, 399) == 0);
    if (if_req && m_if_valid) begin
      if_req  = ($urandom_range(0, 1) == 0);
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (!if_req && $urandom_range(0, 3) == 0) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end else if (if_req && flush && $urandom_range(0, 1) == 0) begin
      if_req = 1'b0;
    end
    if ((d_req && m_d_valid) || (!d_req && $urandom_range(0, 3) == 0)) begin
      d_req   = d_req ? ($urandom_range(0, 1) == 0) : 1'b1;
      d_we    = ($urandom_range(0, 1) == 0);
      d_be    = 4'($urandom);
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    mem_ack   = m_mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    mem_rdata = $urandom;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt;
    int          stores;
    logic [31:0] saved;
    string       exp_seq;
    model_reset();

    // Reset state
    rst = 1'b1;
    tick(); tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;
    tick();

    // Single fetch with a zero-wait memory
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("f_stall_c0", stall_if, 1'b1);
    tick();
    check("f_mem_req", mem_req, 1'b1);
    check("f_mem_addr", mem_addr, 32'h100);
    check("f_mem_be", mem_be, 4'hF);
    check("f_mem_we", mem_we, 1'b0);
    check("f_stall_c1", stall_if, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h00A0_0093;
    tick();
    check("f_if_valid", if_valid, 1'b1);
    check("f_if_rdata", if_rdata, 32'h00A0_0093);
    check("f_mem_req_drop", mem_req, 1'b0);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("f_valid_once", if_valid, 1'b0);

    // Simultaneous requests: data first, fetch after
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
    tick();
    check("both_first_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("both_d_valid", d_valid, 1'b1);
    check("both_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    check("both_second_addr", mem_addr, 32'h104);
    check("both_second_req", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    check("both_if_valid", if_valid, 1'b1);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Data burst limit under continuous fetch pressure
    glog.delete();
    stores = 0;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h3000; d_wdata = 32'h5555_0000;
    for (int c = 0; c < 80 && stores < 5; c++) begin
      tick();
      mem_ack = m_mem_req; mem_rdata = $urandom;
      if (m_d_valid) begin
        stores++;
        d_addr += 4; d_wdata = $urandom;
        if (stores == 5) d_req = 1'b0;
      end
      if (m_if_valid) if_addr += 4;
    end
    check("burst_stores_done", stores, 5);
    for (int c = 0; c < 12; c++) begin
      tick();
      mem_ack = m_mem_req; mem_rdata = $urandom;
      if (m_if_valid) if_req = 1'b0;
    end
    mem_ack = 1'b0;
    exp_seq = "DDDDFD";
    if (glog.size() < 6) check("burst_grant_count", glog.size(), 6);
    else for (int i = 0; i < 6; i++) check($sformatf("burst_grant_%0d", i), glog[i], exp_seq[i]);

    // Flush during a fetch discards the response
    saved = if_rdata;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    check("fl_mem_req", mem_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    check("fl_no_valid", if_valid, 1'b0);
    check("fl_rdata_kept", if_rdata, saved);
    mem_ack = 1'b0;
    tick();
    check("fl_idle_req", mem_req, 1'b0);
    // Flush in IDLE blocks the fetch grant for that cycle only
    if_req = 1'b1; if_addr = 32'h304; flush = 1'b1;
    tick();
    check("fl_blocks_grant", mem_req, 1'b0);
    flush = 1'b0;
    tick();
    check("fl_late_grant", mem_req, 1'b1);
    check("fl_late_addr", mem_addr, 32'h304);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    check("fl_late_valid", if_valid, 1'b1);
    if_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      tick();
    end
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Ack in the final wait cycle beats the timeout
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      mem_ack = 1'b0;
      if (d_valid) break;
      if (mem_req) cnt++;
      if (cnt == TIMEOUT_CYC) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
      end
    end
    check("race_req_cycles", cnt, TIMEOUT_CYC);
    check("race_d_valid", d_valid, 1'b1);
    check("race_d_rdata", d_rdata, 32'hCAFE_0001);
    check("race_bus_err", bus_err, 1'b0);
    d_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Load that never gets an ack
    d_req = 1'b1; d_addr = 32'h700;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (d_valid) break;
      if (mem_req) cnt++;
    end
    check("to_req_cycles", cnt, TIMEOUT_CYC);
    check("to_d_valid", d_valid, 1'b1);
    check("to_d_rdata", d_rdata, 32'h0);
    check("to_bus_err", bus_err, 1'b1);
    d_req = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    check("to_bus_err_sticky", bus_err, 1'b1);
    rst = 1'b1;
    tick();
    check("to_bus_err_cleared", bus_err, 1'b0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a data transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    tick();
    check("mr_mem_req", mem_req, 1'b1);
    rst = 1'b1; d_req = 1'b0;
    tick();
    check("mr_req_dropped", mem_req, 1'b0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    check("mr_late_ack_req", mem_req, 1'b0);
    mem_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("mr_no_d_valid", d_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
